// File: rtl/serial_compare_ctrl.sv
// Serial MSB-first magnitude comparator sequencing the one-bit g/e cascade cell.
// Replaces a WIDTH-deep combinational compare chain with a start/busy/done handshake.
module serial_compare_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic                    busy,
    output logic                    done,
    output logic                    a_lt_b,
    output logic                    a_eq_b,
    output logic                    a_gt_b,
    output logic [$clog2(WIDTH):0]  steps
);

    localparam int IW = $clog2(WIDTH);
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [IW-1:0]    idx_q;
    logic [SW-1:0]    cnt_q;
    logic             e_q;
    logic             g_q;
    logic             l_q;
    logic             busy_q;
    logic             done_q;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;
    logic [SW-1:0]    steps_q;

    logic             ai;
    logic             bi;
    logic             g_d;
    logic             l_d;
    logic             e_d;
    logic [SW-1:0]    cnt_d;
    logic             last_step;

    // One cascade step: g tracks "B greater", l tracks "A greater", e stays set while bits match.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        ai        = a_sh_q[idx_q];
        bi        = b_sh_q[idx_q];
        g_d       = g_q | (e_q & ~ai &  bi);
        l_d       = l_q | (e_q &  ai & ~bi);
        e_d       = e_q & ~(ai ^ bi);
        cnt_d     = cnt_q + SW'(1);
        last_step = (idx_q == '0) || (EARLY_EXIT && !e_d);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: operand shadows are reset too, so an index into them never reads X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            idx_q   <= IW'(WIDTH - 1);
            cnt_q   <= '0;
            e_q     <= 1'b1;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        idx_q   <= IW'(WIDTH - 1);
                        cnt_q   <= '0;
                        e_q     <= 1'b1;
                        g_q     <= 1'b0;
                        l_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    g_q   <= g_d;
                    l_q   <= l_d;
                    e_q   <= e_d;
                    cnt_q <= cnt_d;
                    if (last_step) begin
                        lt_q    <= g_d;
                        gt_q    <= l_d;
                        eq_q    <= e_d;
                        steps_q <= cnt_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_lt_b = lt_q;
    assign a_eq_b = eq_q;
    assign a_gt_b = gt_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl (WIDTH=4) with early-exit and full-run instances.
module tb_serial_compare_ctrl;

    localparam int W  = 4;
    localparam int SW = $clog2(W) + 1;

    typedef struct {
        int lt;
        int eq;
        int gt;
        int st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    start_w = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [1:0]    busy_w, done_w, lt_w, eq_w, gt_w;
    logic [SW-1:0] steps0, steps1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .a(a), .b(b),
        .busy(busy_w[0]), .done(done_w[0]), .a_lt_b(lt_w[0]), .a_eq_b(eq_w[0]),
        .a_gt_b(gt_w[0]), .steps(steps0)
    );

    serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .a(a), .b(b),
        .busy(busy_w[1]), .done(done_w[1]), .a_lt_b(lt_w[1]), .a_eq_b(eq_w[1]),
        .a_gt_b(gt_w[1]), .steps(steps1)
    );

    // Reference: plain magnitude compare; steps = bits walked up to the first difference.
    function automatic exp_t model(int av, int bv, bit ee);
        exp_t r;
        bit   found = 1'b0;
        r.lt = (av < bv) ? 1 : 0;
        r.eq = (av == bv) ? 1 : 0;
        r.gt = (av > bv) ? 1 : 0;
        r.st = W;
        if (ee) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (!found && (av[i] != bv[i])) begin
                    r.st  = W - i;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(int sel, string tag, exp_t e);
        chk({tag, "_lt"}, 32'(lt_w[sel]), e.lt);
        chk({tag, "_eq"}, 32'(eq_w[sel]), e.eq);
        chk({tag, "_gt"}, 32'(gt_w[sel]), e.gt);
        chk({tag, "_steps"}, sel != 0 ? 32'(steps1) : 32'(steps0), e.st);
    endtask

    task automatic push_exp(int sel, logic [W-1:0] av, logic [W-1:0] bv);
        if (sel != 0) q1.push_back(model(int'(av), int'(bv), 1'b0));
        else          q0.push_back(model(int'(av), int'(bv), 1'b1));
    endtask

    // Drive one start pulse; returns just after the accepting edge.
    task automatic launch(int sel, logic [W-1:0] av, logic [W-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start_w[sel] = 1'b1;
        push_exp(sel, av, bv);
        @(posedge clk);
        #1;
        start_w[sel] = 1'b0;
    endtask

    // Wait (bounded) for done, check latency from the accepting edge, pop and compare results.
    task automatic wait_done(int sel, int lat, string tag);
        int   n = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            seen = done_w[sel];
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_at_done"}, 32'(busy_w[sel]), 1);
        if (sel != 0) chk({tag, "_sb_nonempty"}, q1.size(), 1);
        else          chk({tag, "_sb_nonempty"}, q0.size(), 1);
        if (sel != 0 && q1.size() > 0) begin
            e = q1.pop_front();
            chk_flags(sel, tag, e);
        end else if (sel == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            chk_flags(sel, tag, e);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(done_w[sel]), 0);
        chk({tag, "_idle_after_done"}, 32'(busy_w[sel]), 0);
    endtask

    initial begin
        exp_t hold;

        // Reset held 3 cycles, then 10 idle cycles.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {busy_w, done_w, lt_w, eq_w, gt_w, steps0, steps1}, 0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_outputs", {busy_w, done_w, lt_w, eq_w, gt_w, steps0, steps1}, 0);
        end

        // Equal operands: full walk.
        launch(0, 4'b1011, 4'b1011);
        wait_done(0, 4, "equal");

        // MSB differs: early exit after one step, full walk without early exit.
        launch(0, 4'b0111, 4'b1000);
        wait_done(0, 1, "msb_exit");
        launch(1, 4'b0111, 4'b1000);
        wait_done(1, 4, "msb_noexit");

        // A greater at LSB; flags hold through idle cycles.
        launch(0, 4'b0101, 4'b0100);
        wait_done(0, 4, "lsb_gt");
        hold = model(5, 4, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk_flags(0, "hold", hold);
            chk("hold_done", 32'(done_w[0]), 0);
        end

        // Start held high; operands change after capture.
        @(negedge clk);
        a = 4'd3;
        b = 4'd9;
        start_w[0] = 1'b1;
        push_exp(0, 4'd3, 4'd9);
        @(posedge clk);
        #1;
        a = 4'd9;
        b = 4'd3;
        wait_done(0, 1, "captured");
        push_exp(0, 4'd9, 4'd3);
        @(posedge clk);
        #1;
        chk("restart_no_done", 32'(done_w[0]), 0);
        chk("restart_busy", 32'(busy_w[0]), 1);
        start_w[0] = 1'b0;
        wait_done(0, 1, "second");

        // Reset in the middle of a compare.
        launch(0, 4'd2, 4'd2);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {busy_w[0], done_w[0], lt_w[0], eq_w[0], gt_w[0], steps0}, 0);
        q0.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midreset_no_done", 32'(done_w[0]), 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("postreset_no_done", {busy_w[0], done_w[0]}, 0);
        end
        launch(0, 4'd14, 4'd1);
        wait_done(0, 1, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
